// File: rtl/sqrt_pkg.sv
// Shared types and constants for the iterative square-root unit.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ROUND_FLOOR   = 0;
  localparam int ROUND_NEAREST = 1;

  // Iteration counter width: clog2(WIDTH/2), at least one bit.
  function automatic int cnt_width(input int width);
    return (width / 2 > 1) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration (combinational).
// Appends two radicand bits to the partial remainder, tries to subtract
// (4*root + 1), and keeps the difference only when it is non-negative.
module sqrt_step #(
  parameter int H = 4
) (
  input  logic [H+1:0] rem,
  input  logic [H-1:0] root,
  input  logic [1:0]   pair,
  output logic [H+1:0] rem_next,
  output logic         bit_next
);

  logic [H+3:0] shifted;
  logic [H+3:0] trial;
  logic [H+3:0] diff;

  // Trial subtraction and restore decision for the next root bit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rem_next = '0;
    bit_next = 1'b0;
    shifted  = {rem, pair};
    trial    = {2'b00, root, 2'b01};
    diff     = shifted - trial;
    if (shifted >= trial) begin
      rem_next = diff[H+1:0];
      bit_next = 1'b1;
    end else begin
      rem_next = shifted[H+1:0];
    end
  end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root: WIDTH/2 iterations per operation, one root
// bit per clock, optional round-to-nearest on the final result.
module sqrt_iter
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ROUND = ROUND_FLOOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   x_in,
  input  logic               x_ready,
  output logic               busy,
  output logic [WIDTH/2-1:0] y_out,
  output logic [WIDTH/2:0]   rem_out,
  output logic               y_ready,
  output logic               overrun
);

  localparam int H  = WIDTH / 2;
  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  logic [WIDTH-1:0] x_reg;
  logic [H+1:0]    rem_reg;
  logic [H-1:0]    root_reg;
  logic [CW-1:0]   cnt;

  logic [H+1:0]    rem_step;
  logic            bit_step;
  logic [H-1:0]    root_next;
  logic [H-1:0]    rounded;

  sqrt_step #(.H(H)) u_step (
    .rem      (rem_reg),
    .root     (root_reg),
    .pair     (x_reg[WIDTH-1 -: 2]),
    .rem_next (rem_step),
    .bit_next (bit_step)
  );

  if (H > 1) begin : g_root_shift
    assign root_next = {root_reg[H-2:0], bit_step};
  end else begin : g_root_single
    assign root_next = bit_step;
  end

  // Final-result rounding: bump the floor root when the remainder exceeds it,
  // saturating at the all-ones root.
  always_comb begin
    rounded = root_next;
    if (ROUND == ROUND_NEAREST && rem_step[H:0] > {1'b0, root_next}) begin
      rounded = (&root_next) ? root_next : root_next + H'(1);
    end
  end

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data registers are reset too, so outputs read 0 right after reset.
      state    <= IDLE;
      x_reg    <= '0;
      rem_reg  <= '0;
      root_reg <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      y_out    <= '0;
      rem_out  <= '0;
      y_ready  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      y_ready <= 1'b0;
      overrun <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (x_ready) begin
            x_reg    <= x_in;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt      <= CW'(H - 1);
            busy     <= 1'b1;
            state    <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          overrun  <= x_ready;
          x_reg    <= {x_reg[WIDTH-3:0], 2'b00};
          rem_reg  <= rem_step;
          root_reg <= root_next;
          if (cnt == '0) begin
            busy    <= 1'b0;
            y_ready <= 1'b1;
            y_out   <= rounded;
            rem_out <= rem_step[H:0];
            state   <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Self-checking bench: three instances (8-bit floor, 8-bit rounded, 16-bit
// floor) checked against an arithmetic square-root model.
module tb_sqrt_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]  a_x_in = '0, b_x_in = '0;
  logic [15:0] c_x_in = '0;
  logic        a_x_ready = 1'b0, b_x_ready = 1'b0, c_x_ready = 1'b0;
  logic        a_busy, b_busy, c_busy;
  logic [3:0]  a_y_out, b_y_out;
  logic [7:0]  c_y_out;
  logic [4:0]  a_rem_out, b_rem_out;
  logic [8:0]  c_rem_out;
  logic        a_y_ready, b_y_ready, c_y_ready;
  logic        a_overrun, b_overrun, c_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sqrt_iter #(.WIDTH(8), .ROUND(0)) u_a (
    .clk(clk), .rst(rst), .x_in(a_x_in), .x_ready(a_x_ready), .busy(a_busy),
    .y_out(a_y_out), .rem_out(a_rem_out), .y_ready(a_y_ready), .overrun(a_overrun)
  );
  sqrt_iter #(.WIDTH(8), .ROUND(1)) u_b (
    .clk(clk), .rst(rst), .x_in(b_x_in), .x_ready(b_x_ready), .busy(b_busy),
    .y_out(b_y_out), .rem_out(b_rem_out), .y_ready(b_y_ready), .overrun(b_overrun)
  );
  sqrt_iter #(.WIDTH(16), .ROUND(0)) u_c (
    .clk(clk), .rst(rst), .x_in(c_x_in), .x_ready(c_x_ready), .busy(c_busy),
    .y_out(c_y_out), .rem_out(c_rem_out), .y_ready(c_y_ready), .overrun(c_overrun)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model: plain integer square root.
  function automatic longint isqrt(input longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic longint sqrt_round(input longint x, input int h);
    longint r = isqrt(x);
    longint m = (longint'(1) << h) - 1;
    if (x - r * r > r) r = (r + 1 > m) ? m : r + 1;
    return r;
  endfunction

  // Start one operation on all three instances and check results and latency.
  task automatic op(input logic [7:0] xa, input logic [7:0] xb, input logic [15:0] xc);
    bit da = 0, db = 0, dc = 0;
    longint prev_c;
    @(negedge clk);
    a_x_in = xa; b_x_in = xb; c_x_in = xc;
    a_x_ready = 1'b1; b_x_ready = 1'b1; c_x_ready = 1'b1;
    prev_c = c_y_out;
    @(posedge clk); #1;
    check("busy_a_start", a_busy, 1);
    check("busy_c_start", c_busy, 1);
    @(negedge clk);
    a_x_ready = 1'b0; b_x_ready = 1'b0; c_x_ready = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (e == 5) check("hold_c_calc", c_y_out, prev_c);
      if (a_y_ready && !da) begin
        da = 1;
        check("lat_a", e, 4);
        check("y_a", a_y_out, isqrt(xa));
        check("rem_a", a_rem_out, xa - isqrt(xa) * isqrt(xa));
        check("busy_a_done", a_busy, 0);
      end
      if (b_y_ready && !db) begin
        db = 1;
        check("lat_b", e, 4);
        check("y_b", b_y_out, sqrt_round(xb, 4));
        check("rem_b", b_rem_out, xb - isqrt(xb) * isqrt(xb));
      end
      if (c_y_ready && !dc) begin
        dc = 1;
        check("lat_c", e, 8);
        check("y_c", c_y_out, isqrt(xc));
        check("rem_c", c_rem_out, xc - isqrt(xc) * isqrt(xc));
      end
    end
    if (!da) check("timeout_a", 0, 1);
    if (!db) check("timeout_b", 0, 1);
    if (!dc) check("timeout_c", 0, 1);
    check("y_ready_a_one_cycle", a_y_ready, 0);
  endtask

  initial begin
    #1;
    check("rst_busy", a_busy, 0);
    check("rst_y", c_y_out, 0);
    check("rst_rem", c_rem_out, 0);
    check("rst_y_ready", b_y_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed corner values.
    op(8'd203, 8'd210, 16'd65535);
    op(8'd0,   8'd211, 16'd40000);
    op(8'd255, 8'd255, 16'd0);
    op(8'd1,   8'd2,   16'd1);

    // Randomized operations.
    for (int i = 0; i < 30; i++) op(8'($urandom), 8'($urandom), 16'($urandom));

    // Overrun during CALC, then back-to-back start from DONE.
    @(negedge clk); a_x_in = 8'd100; a_x_ready = 1'b1;
    @(posedge clk);                              // capture edge
    @(negedge clk); a_x_ready = 1'b0;
    @(posedge clk);                              // edge 1
    @(negedge clk); a_x_in = 8'd9; a_x_ready = 1'b1;
    @(posedge clk); #1;                          // edge 2
    check("overrun_pulse", a_overrun, 1);
    check("overrun_busy", a_busy, 1);
    @(negedge clk); a_x_ready = 1'b0;
    @(posedge clk); #1;                          // edge 3
    check("overrun_clear", a_overrun, 0);
    @(posedge clk); #1;                          // edge 4
    check("ovr_y_ready", a_y_ready, 1);
    check("ovr_y", a_y_out, 10);
    check("ovr_rem", a_rem_out, 0);
    @(negedge clk); a_x_in = 8'd9; a_x_ready = 1'b1;
    @(posedge clk); #1;                          // edge 5: capture from DONE
    check("b2b_busy", a_busy, 1);
    check("b2b_no_overrun", a_overrun, 0);
    @(negedge clk); a_x_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; check("b2b_no_early", a_y_ready, 0); end
    @(posedge clk); #1;                          // edge 9
    check("b2b_y_ready", a_y_ready, 1);
    check("b2b_y", a_y_out, 3);
    check("b2b_rem", a_rem_out, 0);

    // Reset in the middle of a calculation.
    op(8'd203, 8'd211, 16'd65535);
    @(negedge clk); a_x_in = 8'd200; a_x_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); a_x_ready = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_y", a_y_out, 0);
    check("mid_rst_rem", a_rem_out, 0);
    check("mid_rst_y_c", c_y_out, 0);
    check("mid_rst_y_ready", a_y_ready, 0);
    @(negedge clk); rst = 1'b0;
    begin
      int seen = 0;
      repeat (8) begin @(posedge clk); #1; if (a_y_ready) seen++; end
      check("mid_rst_no_y_ready", seen, 0);
    end
    op(8'd144, 8'd143, 16'd12345);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
